// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame sequencer.
package ws2812_pkg;
  localparam int PIXEL_W              = 24;
  localparam int DEFAULT_RESET_CYCLES = 3000;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DRAIN,
    S_LATCH
  } seq_state_t;
endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel buffer: simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);
  pixel_t mem [DEPTH];

  // Write and registered read share the edge, so the read sees pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Frame sequencer: streams the pixel buffer to the WS2812 bit encoder one GRB word
// per LED, waits for the encoder to drain, then holds the latch gap.
// Optional macro WS2812_AUTO_REFRESH_EN: any buffer write schedules a refresh.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  output logic              px_valid,
  output logic [23:0]       px_data,
  input  logic              px_ready,
  input  logic              enc_busy,
  output logic              busy,
  output logic              frame_done
);
  localparam int                CNT_W     = $clog2(RESET_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RESET_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pending_q;
  logic              go;
  logic              last;
  pixel_t            rd_data;

  assign last = (addr_q == LAST_ADDR);

`ifdef WS2812_AUTO_REFRESH_EN
  logic dirty_q;
  assign go = start | pending_q | dirty_q;

  // Any write marks the buffer dirty; a new write wins over the clear on frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          dirty_q <= 1'b0;
    else if (wr_en)                      dirty_q <= 1'b1;
    else if (state_q == S_IDLE && go)    dirty_q <= 1'b0;
  end
`else
  assign go = start | pending_q;
`endif

  ws2812_pixel_ram #(.DEPTH(NUM_LEDS), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (state_q == S_LOAD),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  // Pixel word is only exposed while offered, keeping px_data at zero otherwise.
  assign px_data = px_valid ? rd_data : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs; busy drops in the same cycle frame_done pulses.
  always_comb begin
    state_d    = state_q;
    px_valid   = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND: begin
        px_valid = 1'b1;
        if (px_ready) state_d = last ? S_DRAIN : S_LOAD;
      end
      S_DRAIN: if (!enc_busy) state_d = S_LATCH;
      S_LATCH: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
          busy       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and latch-gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE:  if (go) addr_q <= '0;
        S_SEND:  if (px_ready && !last) addr_q <= addr_q + 1'b1;
        S_DRAIN: if (!enc_busy) cnt_q <= CNT_LOAD;
        S_LATCH: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // One pending refresh remembered while a frame runs; consumed on the way out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 pending_q <= 1'b0;
    else if (state_q == S_IDLE) pending_q <= 1'b0;
    else if (start)             pending_q <= 1'b1;
  end
endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Self-checking bench for ws2812_frame_sequencer (NUM_LEDS=4, RESET_CYCLES=10).
// Expected handshake order, pixel data and frame timing come from a cycle-count
// model of the frame protocol plus an array mirror of the pixel buffer.
module tb_ws2812_frame_sequencer;
  localparam int N = 4;
  localparam int R = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        start = 1'b0;
  logic        px_ready = 1'b0;
  logic        enc_busy = 1'b0;
  logic        px_valid, busy, frame_done;
  logic [23:0] px_data;

  int checks = 0;
  int errors = 0;
  logic [23:0] model [N];
  bit          known [N];

  ws2812_frame_sequencer #(.NUM_LEDS(N), .RESET_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .enc_busy(enc_busy), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic wr(input int a, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = d;
    model[a] = d; known[a] = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // mode 0: start pulse at t=0; mode 1: frame launched by a pending start;
  // mode 2: frame launched by a write of 0xABCDEF to LED 3 (auto refresh).
  task automatic run_frame(input int mode, input int stall_px, input int stall_len,
                           input int ebusy, input bit rnd, input bit extra);
    int k = 0, last_hs = -1, fd = -1, stall_cnt = 0;
    int first_valid, nv;
    bit done = 1'b0;
    logic exp_busy, exp_fd, exp_valid;
    first_valid = (mode == 2) ? 3 : 2;
    nv = first_valid;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0; px_ready = 1'b0; enc_busy = 1'b0;
      if (t == 0 && mode == 0) start = 1'b1;
      if (t == 0 && mode == 2) begin
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 24'hABCDEF;
        model[3] = 24'hABCDEF; known[3] = 1'b1;
      end
      if (extra && (t == 3 || t == 5 || t == 7)) start = 1'b1;

      exp_busy  = (t >= first_valid - 1) && !(last_hs >= 0 && t >= fd);
      exp_fd    = (last_hs >= 0 && t == fd);
      exp_valid = (k < N && t >= nv);
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL busy t=%0d got %b exp %b", t, busy, exp_busy);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++; $display("FAIL frame_done t=%0d got %b exp %b", t, frame_done, exp_fd);
      end
      checks++;
      if (px_valid !== exp_valid) begin
        errors++; $display("FAIL px_valid t=%0d px=%0d got %b exp %b", t, k, px_valid, exp_valid);
      end
      if (exp_valid && known[k]) begin
        checks++;
        if (px_data !== model[k]) begin
          errors++; $display("FAIL px_data t=%0d px=%0d got %h exp %h", t, k, px_data, model[k]);
        end
      end

      if (exp_valid) begin
        if (k == stall_px && stall_cnt < stall_len) stall_cnt++;
        else px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (px_ready) begin
          if (k == N - 1) begin
            last_hs = t;
            fd = t + 1 + ebusy + R;
          end
          k++;
          nv = t + 2;
        end
      end else if (rnd) begin
        px_ready = 1'($urandom_range(0, 1));
      end
      if (last_hs >= 0 && t > last_hs && t <= last_hs + ebusy) enc_busy = 1'b1;
      if (last_hs >= 0 && t == fd) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL frame_timeout got %0d pixels exp %0d", k, N);
    end
    px_ready = 1'b0; enc_busy = 1'b0;
  endtask

  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; px_ready = 1'b1; wr_en = 1'b0;
      checks++;
      if (busy !== 1'b0 || px_valid !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL idle i=%0d got busy=%b valid=%b done=%b exp 0", i, busy, px_valid, frame_done);
      end
    end
    px_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (px_valid !== 1'b0 || px_data !== 24'h0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset got valid=%b data=%h busy=%b done=%b exp 0", px_valid, px_data, busy, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    wr(0, 24'h00FF00); wr(1, 24'h0000FF); wr(2, 24'hFF0000); wr(3, 24'h123456);
    run_frame(0, -1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_frame(0, 1, 7, 0, 1'b0, 1'b0);
  endtask

  task automatic test_enc_busy();
    run_frame(0, -1, 0, 20, 1'b0, 1'b0);
  endtask

  task automatic test_pending();
    run_frame(0, -1, 0, 0, 1'b0, 1'b1);
    run_frame(1, -1, 0, 0, 1'b0, 1'b0);
    test_idle(20);
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    bit hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      start = 1'b0; px_ready = 1'b0;
      if (px_valid) begin
        if (hs == 2) begin hit = 1'b1; break; end
        px_ready = 1'b1; hs++;
      end
    end
    checks++;
    if (!hit || px_data !== model[2]) begin
      errors++; $display("FAIL mid_send_px2 got %h exp %h", px_data, model[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (px_valid !== 1'b0 || px_data !== 24'h0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got valid=%b data=%h busy=%b done=%b exp 0", px_valid, px_data, busy, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, -1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      for (int a = 0; a < N; a++) wr(a, 24'($urandom));
      run_frame(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 6)), 1'b1, 1'b0);
    end
  endtask

  task automatic test_auto_refresh();
    run_frame(2, -1, 0, 0, 1'b0, 1'b0);
    test_idle(30);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin model[i] = '0; known[i] = 1'b0; end
    test_reset();
`ifdef WS2812_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_basic();
    test_stall();
    test_enc_busy();
    test_pending();
    test_reset_mid();
    test_random();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
